// File: rtl/regfile_write_arbiter_if.sv
// Writeback-to-register-file bus: two requester handshakes plus the shared write port.
// The master modport is the requester/observer side; the slave modport is the arbiter.
interface regfile_write_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic              b_ready;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              init_done;
   logic [15:0]       conflict_cnt;

   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata, init_done, conflict_cnt
   );

   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      output a_ready, b_ready, rf_we, rf_waddr, rf_wdata, init_done, conflict_cnt
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register-file write port; clears all registers after reset.
// Optional macro REGFILE_WRITE_ARBITER_STATS_EN builds the saturating contention counter.
module regfile_write_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int NREG   = 32
) (
   input logic                   clk,
   input logic                   rst,
   regfile_write_arbiter_if.slave bus
);
   localparam logic [0:0]        ST_INIT   = 1'b0;
   localparam logic [0:0]        ST_RUN    = 1'b1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_ptr;        // 0: A has priority on contention, 1: B
   logic              r_rf_we;
   logic [ADDR_W-1:0] r_rf_waddr;
   logic [DATA_W-1:0] r_rf_wdata;
   logic              r_init_done;

   logic w_run;
   logic w_a_gnt;
   logic w_b_gnt;

   assign w_run   = (r_state == ST_RUN);
   assign w_a_gnt = w_run & bus.a_valid & (~bus.b_valid | ~r_ptr);
   assign w_b_gnt = w_run & bus.b_valid & (~bus.a_valid |  r_ptr);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_cnt       <= '0;
         r_ptr       <= 1'b0;
         r_rf_we     <= 1'b0;
         r_rf_waddr  <= '0;
         r_rf_wdata  <= '0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_rf_we    <= 1'b1;
               r_rf_waddr <= r_cnt;
               r_rf_wdata <= '0;
               r_cnt      <= r_cnt + 1'b1;
               if (r_cnt == LAST_ADDR) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end
            end
            default: begin
               // x0 is hardwired zero: accept the handshake but never drive WE3 for it
               if (w_a_gnt) begin
                  r_rf_we    <= (bus.a_addr != '0);
                  r_rf_waddr <= bus.a_addr;
                  r_rf_wdata <= bus.a_data;
                  r_ptr      <= 1'b1;
               end else if (w_b_gnt) begin
                  r_rf_we    <= (bus.b_addr != '0);
                  r_rf_waddr <= bus.b_addr;
                  r_rf_wdata <= bus.b_data;
                  r_ptr      <= 1'b0;
               end else begin
                  r_rf_we    <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef REGFILE_WRITE_ARBITER_STATS_EN
   logic [15:0] r_conflict_cnt;
   logic        w_both;

   assign w_both = bus.a_valid & bus.b_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_conflict_cnt <= '0;
      end else if (w_run && w_both && (r_conflict_cnt != 16'hFFFF)) begin
         r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
   end

   assign bus.conflict_cnt = r_conflict_cnt;
`else
   assign bus.conflict_cnt = 16'h0000;
`endif

   assign bus.a_ready   = w_a_gnt;
   assign bus.b_ready   = w_b_gnt;
   assign bus.rf_we     = r_rf_we;
   assign bus.rf_waddr  = r_rf_waddr;
   assign bus.rf_wdata  = r_rf_wdata;
   assign bus.init_done = r_init_done;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: init sweep, arbitration vector table,
// x0 suppression, mid-run reset and contention counter.
module tb_regfile_write_arbiter;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   regfile_write_arbiter_if bus ();

   regfile_write_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic [4:0]  aaddr;
      logic [31:0] adata;
      logic        bv;
      logic [4:0]  baddr;
      logic [31:0] bdata;
      logic        ar;
      logic        br;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   vec_t tv[11];
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd);
      bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
      bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
   endtask

   task automatic init_sweep(input string tag);
      for (int i = 0; i < 32; i++) begin
         #1;
         chk({tag, "_a_ready_low"}, {31'd0, bus.a_ready}, 32'd0);
         step();
         chk({tag, "_we"}, {31'd0, bus.rf_we}, 32'd1);
         chk({tag, "_waddr"}, {27'd0, bus.rf_waddr}, i);
         chk({tag, "_wdata"}, bus.rf_wdata, 32'd0);
         chk({tag, "_init_done"}, {31'd0, bus.init_done}, (i == 31) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      exp_t e;
      logic [15:0] exp_cnt;
      n_checks = 0;
      n_errors = 0;

      //            av  aaddr  adata          bv  baddr  bdata          ar br we waddr  wdata
      tv[0]  = '{1'b1, 5'd6,  32'd10,        1'b1, 5'd9,  32'h2004,     1, 0, 1, 5'd6,  32'd10};
      tv[1]  = '{1'b1, 5'd6,  32'd10,        1'b1, 5'd9,  32'h2004,     0, 1, 1, 5'd9,  32'h2004};
      tv[2]  = '{1'b1, 5'd6,  32'd10,        1'b1, 5'd9,  32'h2004,     1, 0, 1, 5'd6,  32'd10};
      tv[3]  = '{1'b1, 5'd6,  32'd10,        1'b1, 5'd9,  32'h2004,     0, 1, 1, 5'd9,  32'h2004};
      tv[4]  = '{1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  32'd0,        0, 0, 0, 5'd0,  32'd0};
      tv[5]  = '{1'b1, 5'd5,  32'h10,        1'b0, 5'd0,  32'd0,        1, 0, 1, 5'd5,  32'h10};
      tv[6]  = '{1'b0, 5'd0,  32'd0,         1'b1, 5'd0,  32'hDEADBEEF, 0, 1, 0, 5'd0,  32'd0};
      tv[7]  = '{1'b1, 5'd0,  32'h1234,      1'b0, 5'd0,  32'd0,        1, 0, 0, 5'd0,  32'd0};
      tv[8]  = '{1'b1, 5'd31, 32'hFFFFFFFF,  1'b0, 5'd0,  32'd0,        1, 0, 1, 5'd31, 32'hFFFFFFFF};
      tv[9]  = '{1'b0, 5'd0,  32'd0,         1'b1, 5'd17, 32'hCAFE0001, 0, 1, 1, 5'd17, 32'hCAFE0001};
      tv[10] = '{1'b1, 5'd3,  32'd3,         1'b1, 5'd4,  32'd4,        1, 0, 1, 5'd3,  32'd3};

      rst = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      step();
      step();
      chk("rst_we", {31'd0, bus.rf_we}, 32'd0);
      chk("rst_waddr", {27'd0, bus.rf_waddr}, 32'd0);
      chk("rst_wdata", bus.rf_wdata, 32'd0);
      chk("rst_init_done", {31'd0, bus.init_done}, 32'd0);
      chk("rst_conflict", {16'd0, bus.conflict_cnt}, 32'd0);

      // A holds a request through init and must never be granted
      drive(1'b1, 5'd5, 32'd1, 1'b0, 5'd0, 32'd0);
      rst = 1'b0;
      init_sweep("init");
      bus.a_valid = 1'b0;

      for (int i = 0; i < 11; i++) begin
         drive(tv[i].av, tv[i].aaddr, tv[i].adata, tv[i].bv, tv[i].baddr, tv[i].bdata);
         #1;
         chk($sformatf("vec%0d_a_ready", i), {31'd0, bus.a_ready}, {31'd0, tv[i].ar});
         chk($sformatf("vec%0d_b_ready", i), {31'd0, bus.b_ready}, {31'd0, tv[i].br});
         sb.push_back('{tv[i].we, tv[i].waddr, tv[i].wdata});
         step();
         e = sb.pop_front();
         chk($sformatf("vec%0d_we", i), {31'd0, bus.rf_we}, {31'd0, e.we});
         if (e.we) begin
            chk($sformatf("vec%0d_waddr", i), {27'd0, bus.rf_waddr}, {27'd0, e.addr});
            chk($sformatf("vec%0d_wdata", i), bus.rf_wdata, e.data);
         end
         if (i == 3) begin
`ifdef REGFILE_WRITE_ARBITER_STATS_EN
            exp_cnt = 16'd4;
`else
            exp_cnt = 16'd0;
`endif
            chk("conflict_after_4", {16'd0, bus.conflict_cnt}, {16'd0, exp_cnt});
         end
      end
`ifdef REGFILE_WRITE_ARBITER_STATS_EN
      exp_cnt = 16'd5;
`else
      exp_cnt = 16'd0;
`endif
      chk("conflict_after_table", {16'd0, bus.conflict_cnt}, {16'd0, exp_cnt});

      // mid-run reset right after a grant
      drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0);
      #1;
      chk("mid_a_ready", {31'd0, bus.a_ready}, 32'd1);
      step();
      chk("mid_we", {31'd0, bus.rf_we}, 32'd1);
      chk("mid_waddr", {27'd0, bus.rf_waddr}, 32'd7);
      rst = 1'b1;
      bus.a_valid = 1'b0;
      step();
      chk("mid_rst_we", {31'd0, bus.rf_we}, 32'd0);
      chk("mid_rst_init_done", {31'd0, bus.init_done}, 32'd0);
      chk("mid_rst_conflict", {16'd0, bus.conflict_cnt}, 32'd0);
      rst = 1'b0;
      init_sweep("reinit");

      // pointer must be back at A after reset
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
      #1;
      chk("post_rst_a_ready", {31'd0, bus.a_ready}, 32'd1);
      chk("post_rst_b_ready", {31'd0, bus.b_ready}, 32'd0);
      step();
      chk("post_rst_waddr", {27'd0, bus.rf_waddr}, 32'd1);
      chk("post_rst_wdata", bus.rf_wdata, 32'h11);

`ifdef REGFILE_WRITE_ARBITER_STATS_EN
      chk("post_rst_conflict", {16'd0, bus.conflict_cnt}, 32'd1);
      repeat (70000) step();
      chk("conflict_saturated", {16'd0, bus.conflict_cnt}, 32'h0000FFFF);
`else
      repeat (20) step();
      chk("conflict_tied_zero", {16'd0, bus.conflict_cnt}, 32'd0);
`endif
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
